// File: rtl/multi_buffer_stream_ram.sv
// ram_block: single-port-per-direction word RAM bank.
// Synchronous write; registered read that returns the pre-write word on an
// address collision in the same cycle.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write word address
//   wdata  in  write word
//   re     in  read enable
//   raddr  in  read word address
//   rdata  out read word, valid the cycle after re
module ram_block #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array; read and write share the edge, so reads see old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// multi_buffer_stream_ram: BUFF_NUM buffers of 2**ADDR_WIDTH words, written a
// word at a time, read DATA_OUT_WIDTH bits at any byte address (straddling
// words and buffers) through a fixed-latency pipeline into a credit-guarded
// show-ahead output FIFO.
//   clk       in  clock
//   rst       in  asynchronous reset, active high
//   wr_en     in  write strobe
//   wr_addr   in  word address, buffer index in MSBs
//   wr_data   in  write word
//   rd_valid  in  read request valid
//   rd_ready  out read request accepted when rd_valid & rd_ready
//   rd_addr   in  byte address {buffer, word, byte offset}
//   q_valid   out read data valid
//   q_ready   in  consumer accepts q when q_valid & q_ready
//   q         out read data, byte at rd_addr in bits [7:0]
//   count     out entries held in the output FIFO
module multi_buffer_stream_ram #(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned DATA_OUT_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned BUFF_NUM       = 4,
    parameter int unsigned OUT_FIFO_DEPTH = 4,
    localparam int unsigned BW = $clog2(BUFF_NUM),
    localparam int unsigned OW = $clog2(DATA_WIDTH / 8),
    localparam int unsigned CW = $clog2(OUT_FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [BW+ADDR_WIDTH-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [BW+ADDR_WIDTH+OW-1:0] rd_addr,
    output logic                        q_valid,
    input  logic                        q_ready,
    output logic [DATA_OUT_WIDTH-1:0]   q,
    output logic [CW-1:0]               count
);
    localparam int unsigned WAW = BW + ADDR_WIDTH;      // global word address
    localparam int unsigned BAW = WAW - 1;              // bank address
    localparam int unsigned PW  = $clog2(OUT_FIFO_DEPTH);

    logic                  accept;
    logic [WAW-1:0]        rd_word;
    logic [OW-1:0]         rd_off;
    logic [BAW-1:0]        even_raddr;
    logic [BAW-1:0]        odd_raddr;
    logic [DATA_WIDTH-1:0] even_rdata;
    logic [DATA_WIDTH-1:0] odd_rdata;

    logic                  s1_valid;
    logic                  s1_odd;
    logic [OW-1:0]         s1_off;

    logic                  s2_valid;
    logic [OW-1:0]         s2_off;
    logic [DATA_WIDTH-1:0] s2_lo;
    logic [DATA_WIDTH-1:0] s2_hi;
    logic [DATA_OUT_WIDTH-1:0] s2_result;

    logic [DATA_OUT_WIDTH-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credits_used;

    assign accept  = rd_valid & rd_ready;
    assign rd_word = rd_addr[OW +: WAW];
    assign rd_off  = rd_addr[OW-1:0];

    // Words W and W+1 always sit in opposite banks. The odd bank index is
    // W>>1 in both cases; the even bank needs (W+1)>>1 when W is odd, and the
    // carry out of the top bank address wraps the last buffer back to buffer 0.
    assign odd_raddr  = rd_word[WAW-1:1];
    assign even_raddr = rd_word[WAW-1:1] + BAW'(rd_word[0]);

    ram_block #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (BAW)
    ) u_even (
        .clk   (clk),
        .we    (wr_en & ~wr_addr[0]),
        .waddr (wr_addr[WAW-1:1]),
        .wdata (wr_data),
        .re    (accept),
        .raddr (even_raddr),
        .rdata (even_rdata)
    );

    ram_block #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (BAW)
    ) u_odd (
        .clk   (clk),
        .we    (wr_en & wr_addr[0]),
        .waddr (wr_addr[WAW-1:1]),
        .wdata (wr_data),
        .re    (accept),
        .raddr (odd_raddr),
        .rdata (odd_rdata)
    );

    // Stage 1 sideband: tracks the bank reads issued on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_odd   <= 1'b0;
            s1_off   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_odd <= rd_word[0];
                s1_off <= rd_off;
            end
        end
    end

    // Stage 2: bank outputs put back into address order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_off   <= '0;
            s2_lo    <= '0;
            s2_hi    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_off <= s1_off;
                s2_lo  <= s1_odd ? odd_rdata  : even_rdata;
                s2_hi  <= s1_odd ? even_rdata : odd_rdata;
            end
        end
    end

    // Byte shift across the word pair; the upper word only reaches the
    // result when the read runs past the end of the lower word.
    always_comb begin
        s2_result = DATA_OUT_WIDTH'({s2_hi, s2_lo} >> {s2_off, 3'b000});
    end

    assign push = s2_valid;
    assign pop  = q_valid & q_ready;

    // Output FIFO; credits guarantee a free slot for every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(OUT_FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wptr] <= s2_result;
                wptr           <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign q_valid = (count != '0);
    assign q       = fifo_mem[rptr];

    // Credits use the registered count, so a pop frees its slot one cycle later.
    assign credits_used = (CW+1)'(s1_valid) + (CW+1)'(s2_valid) + (CW+1)'(count);
    assign rd_ready     = (credits_used < (CW+1)'(OUT_FIFO_DEPTH));
endmodule
